// File: rtl/cell_ref_cmd_sequencer_if.sv
// Command handshake between the cell-reference sequencer and its consumer.
// Carries the decoded {op,row,col} with valid/ready flow control.
interface cell_ref_cmd_sequencer_if;
    logic [9:0] cmd_col;
    logic [9:0] cmd_row;
    logic [1:0] cmd_op;
    logic       cmd_valid;
    logic       cmd_ready;

    modport master (
        output cmd_col, cmd_row, cmd_op, cmd_valid,
        input  cmd_ready
    );

    modport slave (
        input  cmd_col, cmd_row, cmd_op, cmd_valid,
        output cmd_ready
    );
endinterface

// File: rtl/cell_ref_cmd_sequencer.sv
// Frames UART bytes for the cell-reference parser, pulses its trigger, and
// hands the parsed {op,row,col} downstream over a valid/ready handshake.
module cell_ref_cmd_sequencer #(
    parameter logic [7:0] TERM_CHAR     = 8'h0D,
    parameter int         MIN_LEN       = 5,
    parameter int         MAX_LEN       = 7,
    parameter int         ACTIVE_CYCLES = 2,
    parameter int         SETTLE_CYCLES = 2,
    parameter int         TIMEOUT_CYC   = 100000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [8*MAX_LEN-1:0]     parse_input,
    output logic [2:0]               parse_number,
    output logic                     parse_active,
    input  logic [21:0]              parse_result,
    cell_ref_cmd_sequencer_if.master cmd,
    output logic                     err_len,
    output logic                     err_ovf,
    output logic [7:0]               drop_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {COLLECT, DISCARD, FIRE, SETTLE, OUTPUT} state_t;

    state_t                 state_reg, state_next;
    logic [8*MAX_LEN-1:0]   buf_reg;
    logic [2:0]             count_reg;
    logic [2:0]             number_reg;
    logic [TW-1:0]          gap_reg;
    logic [7:0]             phase_reg;
    logic                   active_reg;
    logic [9:0]             col_reg, row_reg;
    logic [1:0]             op_reg;
    logic                   valid_reg;
    logic                   err_len_reg, err_ovf_reg;
    logic [7:0]             drop_reg;

    logic                   is_term;
    logic [3:0]             len_plus1;
    logic                   store_byte, clear_buf, fire_start, capture, drop;
    logic                   err_len_next, err_ovf_next;

    assign is_term   = (rx_data == TERM_CHAR);
    assign len_plus1 = {1'b0, count_reg} + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= COLLECT;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next   = state_reg;
        store_byte   = 1'b0;
        clear_buf    = 1'b0;
        fire_start   = 1'b0;
        capture      = 1'b0;
        drop         = 1'b0;
        err_len_next = 1'b0;
        err_ovf_next = 1'b0;
        case (state_reg)
            COLLECT: begin
                if (rx_valid) begin
                    if (is_term) begin
                        if (len_plus1 < 4'(MIN_LEN)) begin
                            err_len_next = 1'b1;
                            clear_buf    = 1'b1;
                        end else begin
                            store_byte = 1'b1;
                            fire_start = 1'b1;
                            state_next = FIRE;
                        end
                    end else if (count_reg == 3'(MAX_LEN - 1)) begin
                        err_ovf_next = 1'b1;
                        clear_buf    = 1'b1;
                        state_next   = DISCARD;
                    end else begin
                        store_byte = 1'b1;
                    end
                end else if (count_reg != 3'd0 && gap_reg == TW'(TIMEOUT_CYC - 1)) begin
                    // Stalled partial frame: drop it without flagging an error.
                    clear_buf = 1'b1;
                end
            end
            DISCARD: begin
                if (rx_valid && is_term) begin
                    clear_buf  = 1'b1;
                    state_next = COLLECT;
                end
            end
            FIRE: begin
                drop = rx_valid;
                if (phase_reg == 8'(ACTIVE_CYCLES - 1)) state_next = SETTLE;
            end
            SETTLE: begin
                drop = rx_valid;
                if (phase_reg == 8'(SETTLE_CYCLES - 1)) begin
                    capture    = 1'b1;
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                drop = rx_valid;
                if (valid_reg && cmd.cmd_ready) begin
                    clear_buf  = 1'b1;
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_reg     <= '0;
            count_reg   <= '0;
            number_reg  <= '0;
            gap_reg     <= '0;
            phase_reg   <= '0;
            active_reg  <= 1'b0;
            col_reg     <= '0;
            row_reg     <= '0;
            op_reg      <= '0;
            valid_reg   <= 1'b0;
            err_len_reg <= 1'b0;
            err_ovf_reg <= 1'b0;
            drop_reg    <= '0;
        end else begin
            if (clear_buf) begin
                buf_reg   <= '0;
                count_reg <= '0;
            end else if (store_byte) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (count_reg == 3'(i)) buf_reg[8*i +: 8] <= rx_data;
                end
                count_reg <= len_plus1[2:0];
            end
            if (fire_start) number_reg <= len_plus1[2:0];

            if (state_reg != COLLECT || count_reg == 3'd0 || rx_valid || clear_buf)
                gap_reg <= '0;
            else
                gap_reg <= gap_reg + 1'b1;

            if (state_next != state_reg)
                phase_reg <= '0;
            else if (state_reg == FIRE || state_reg == SETTLE)
                phase_reg <= phase_reg + 8'd1;

            // Trigger tracks the FIRE state exactly, so it can never leak outside it.
            active_reg <= (state_next == FIRE);

            if (capture) begin
                op_reg  <= parse_result[21:20];
                row_reg <= parse_result[19:10];
                col_reg <= parse_result[9:0];
            end
            valid_reg <= (state_reg == OUTPUT) && !(valid_reg && cmd.cmd_ready);

            err_len_reg <= err_len_next;
            err_ovf_reg <= err_ovf_next;
            if (drop && drop_reg != 8'hFF) drop_reg <= drop_reg + 8'd1;
        end
    end

    assign parse_input   = buf_reg;
    assign parse_number  = number_reg;
    assign parse_active  = active_reg;
    assign cmd.cmd_col   = col_reg;
    assign cmd.cmd_row   = row_reg;
    assign cmd.cmd_op    = op_reg;
    assign cmd.cmd_valid = valid_reg;
    assign err_len       = err_len_reg;
    assign err_ovf       = err_ovf_reg;
    assign drop_cnt      = drop_reg;

endmodule
